// File: rtl/card_dealer_pkg.sv
// ============================================================================
// Module : card_dealer_pkg
// Brief  : Shared constants, card codes and FSM state encoding for the dealer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package card_dealer_pkg;

    localparam int DECK_SIZE   = 52;
    localparam int ACE         = 1;
    localparam int JACK        = 11;
    localparam int KING        = 13;
    localparam int FACE_POINTS = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETADDR = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        PRESENT = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/card_dealer_if.sv
// ============================================================================
// Module : card_dealer_if
// Brief  : Dealer-side bus: deck memory port, request handshake, card result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface card_dealer_if #(
    parameter int CARD_W = 4,
    parameter int ADDR_W = 6
);
    logic              i_Shuffled;
    logic              i_ReqCard;
    logic [CARD_W-1:0] i_MemData;
    logic [ADDR_W-1:0] o_Address;
    logic              o_MemClk;
    logic              o_Write;
    logic              o_BusEn;
    logic [CARD_W-1:0] o_Card;
    logic [3:0]        o_Points;
    logic              o_CardValid;
    logic              o_BadCard;
    logic              o_Busy;
    logic              o_DeckEmpty;
    logic [ADDR_W-1:0] o_CardsLeft;

    modport master (
        input  i_Shuffled, i_ReqCard, i_MemData,
        output o_Address, o_MemClk, o_Write, o_BusEn, o_Card, o_Points,
               o_CardValid, o_BadCard, o_Busy, o_DeckEmpty, o_CardsLeft
    );

    modport slave (
        output i_Shuffled, i_ReqCard, i_MemData,
        input  o_Address, o_MemClk, o_Write, o_BusEn, o_Card, o_Points,
               o_CardValid, o_BadCard, o_Busy, o_DeckEmpty, o_CardsLeft
    );
endinterface

`default_nettype wire

// File: rtl/card_dealer_points.sv
// ============================================================================
// Module : card_points
// Brief  : Combinational blackjack value of a card code; flags illegal codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module card_points
    import card_dealer_pkg::*;
#(
    parameter int CARD_W = 4
) (
    input  logic [CARD_W-1:0] i_code,
    output logic [3:0]        o_points,
    output logic              o_bad
);

    logic [31:0] w_code;

    assign w_code = 32'(i_code);

    // Ace reports 1; promotion to 11 belongs to the game logic.
    always_comb begin
        o_points = 4'd0;
        o_bad    = 1'b0;
        if (w_code == 32'(ACE)) begin
            o_points = 4'd1;
        end else if (w_code > 32'(ACE) && w_code < 32'(JACK)) begin
            o_points = 4'(w_code);
        end else if (w_code >= 32'(JACK) && w_code <= 32'(KING)) begin
            o_points = 4'(FACE_POINTS);
        end else begin
            o_bad = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/card_dealer.sv
// ============================================================================
// Module : card_dealer
// Brief  : Deals one card per request from a shuffled deck memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module card_dealer #(
    parameter int DECK_SIZE = card_dealer_pkg::DECK_SIZE,
    parameter int CARD_W    = 4,
    parameter int ADDR_W    = 6
) (
    input  logic          clk,
    input  logic          i_Rst,
    card_dealer_if.master bus
);
    import card_dealer_pkg::*;

    localparam logic [ADDR_W-1:0] C_DECK_END = ADDR_W'(DECK_SIZE);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CARD_W-1:0] r_card;
    logic              r_valid;
    logic              r_memclk;

    logic              w_deck_empty;
    logic [3:0]        w_points;
    logic              w_bad;

    assign w_deck_empty = (r_ptr == C_DECK_END);

    always_ff @(posedge clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_card   <= '0;
            r_valid  <= 1'b0;
            r_memclk <= 1'b0;
        end else if (!bus.i_Shuffled) begin
            // Losing the deck abandons any read and rewinds to the top card.
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_valid  <= 1'b0;
            r_memclk <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_memclk <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_ReqCard && !w_deck_empty) begin
                        r_state <= SETADDR;
                    end
                end
                SETADDR: begin
                    r_memclk <= 1'b1;
                    r_state  <= READ;
                end
                READ: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_card  <= bus.i_MemData;
                    r_valid <= 1'b1;
                    r_state <= PRESENT;
                end
                PRESENT: begin
                    if (!w_deck_empty) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    card_points #(
        .CARD_W (CARD_W)
    ) u_points (
        .i_code   (r_card),
        .o_points (w_points),
        .o_bad    (w_bad)
    );

    assign bus.o_Address   = r_ptr;
    assign bus.o_MemClk    = r_memclk & bus.i_Shuffled;
    assign bus.o_Write     = 1'b0;
    assign bus.o_BusEn     = bus.i_Shuffled;
    assign bus.o_Card      = r_card;
    assign bus.o_Points    = w_points;
    assign bus.o_CardValid = r_valid;
    assign bus.o_BadCard   = r_valid & w_bad;
    assign bus.o_Busy      = (r_state != IDLE);
    assign bus.o_DeckEmpty = w_deck_empty;
    assign bus.o_CardsLeft = C_DECK_END - r_ptr;

endmodule

`default_nettype wire
